cube_raster_gen: RTL and testbench

- Parametrised isometric-cube rasteriser for the MTL display pipeline: replaces per-edge line instances with three shared row DDAs.
- Classifies each pixel as top, left or right face for a cube of configurable size.
- Cube position is double-buffered at frame start, so moving the cube never tears mid-frame.
- Sits between the display timing counters and the colour mux.

---
 rtl/cube_pkg.sv | 19 +
 rtl/cube_row_dda.sv | 69 ++++++
 rtl/cube_raster_gen.sv | 157 +++++++++++++++
 tb/tb_cube_raster_gen.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cube_pkg.sv
// Shared types for the isometric cube rasteriser: default coordinate widths,
// span type wide enough to hold negative bounds, and the line-update FSM states.
package cube_pkg;

    localparam int CUBE_XW = 11;
    localparam int CUBE_YW = 10;

    typedef logic [CUBE_XW-1:0]        coord_t;
    typedef logic [CUBE_YW-1:0]        row_t;
    typedef logic signed [CUBE_XW+1:0] span_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        STEP = 2'd2,
        SPAN = 2'd3
    } state_t;

endpackage

// File: rtl/cube_row_dda.sv
// One row DDA: tracks q(n) = floor(n*W/H) incrementally as n rises by one per line.
// q stops growing once it reaches W, since every consumer clips at W.
module cube_row_dda #(
    parameter int W  = 90,
    parameter int H  = 50,
    parameter int WQ = 1,
    parameter int WR = 40,
    parameter int QW = 7,
    parameter int RW = 7,
    parameter int NW = 13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 upd_i,
    input  logic signed [NW-1:0] n_i,
    output logic [QW-1:0]        q_o,
    output logic                 valid_o
);

    localparam logic [QW-1:0] WQ_Q = QW'(WQ);
    localparam logic [QW-1:0] W_Q  = QW'(W);
    localparam logic [RW-1:0] WR_R = RW'(WR);
    localparam logic [RW-1:0] H_R  = RW'(H);

    logic [QW-1:0] q_q, q_d, q_sum;
    logic [RW-1:0] r_q, r_d, r_sum;
    logic          v_q, v_d;

    always_comb begin
        q_d   = q_q;
        r_d   = r_q;
        v_d   = v_q;
        q_sum = q_q + WQ_Q;
        r_sum = r_q + WR_R;
        if (upd_i) begin
            if (n_i == '0) begin
                q_d = '0;
                r_d = '0;
                v_d = 1'b1;
            end else if (n_i[NW-1]) begin
                v_d = 1'b0;
            end else if (q_q < W_Q) begin
                if (r_sum >= H_R) begin
                    q_d = q_sum + 1'b1;
                    r_d = r_sum - H_R;
                end else begin
                    q_d = q_sum;
                    r_d = r_sum;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
            r_q <= '0;
            v_q <= 1'b0;
        end else begin
            q_q <= q_d;
            r_q <= r_d;
            v_q <= v_d;
        end
    end

    assign q_o     = q_q;
    assign valid_o = v_q;

endmodule

// File: rtl/cube_raster_gen.sv
// Isometric cube rasteriser: three shared row DDAs produce per-line face spans,
// then each pixel is classified top/left/right against the registered spans.
module cube_raster_gen
    import cube_pkg::*;
#(
    parameter int XW = CUBE_XW,
    parameter int YW = CUBE_YW,
    parameter int W  = 90,
    parameter int H  = 50,
    parameter int D  = 120
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_start,
    input  logic          line_start,
    input  logic [XW-1:0] x_cnt,
    input  logic [YW-1:0] y_cnt,
    input  logic [XW-1:0] x_offset,
    input  logic [YW-1:0] y_offset,
    input  logic          enable,
    output logic          top_face,
    output logic          left_face,
    output logic          right_face,
    output logic          busy
);

    localparam int WQ = W / H;
    localparam int WR = W % H;
    localparam int NW = YW + 3;
    localparam int QW = $clog2(W + WQ + 2);
    localparam int RW = $clog2(2 * H);
    localparam int SW = XW + 2;

    typedef logic signed [NW-1:0] arg_t;
    typedef logic signed [SW-1:0] spn_t;

    localparam arg_t H_N   = arg_t'(H);
    localparam arg_t H2_N  = arg_t'(2 * H);
    localparam arg_t HD_N  = arg_t'(H + D);
    localparam arg_t H2D_N = arg_t'(2 * H + D);
    localparam spn_t W_S   = spn_t'(W);
    localparam spn_t WM1_S = spn_t'(W - 1);
    localparam spn_t ONE_S = spn_t'(1);

    state_t        state_q, state_d;
    logic [XW-1:0] xo_q, xo_d, lxo_q;
    logic [YW-1:0] yo_q, yo_d;
    logic          seen_q;
    arg_t          dy_q, dy_d, n_b, n_c;
    logic [QW-1:0] qa, qb, qc;
    logic          va, vb, vc;
    spn_t          xo_s, qa_s, qb_s, qc_s, half, hi, lo, xs;
    logic          in_a, in_b, top_ok_d, lr_ok_d, top_ok_q, lr_ok_q;
    spn_t          top_lo_q, top_hi_q, lft_lo_q, lft_hi_q, rgt_lo_q, rgt_hi_q;
    logic          hit_t, hit_l, hit_r, gate;
    logic          top_q, left_q, right_q;

    // A frame_start coinciding with line_start must already steer that line.
    assign xo_d = frame_start ? x_offset : xo_q;
    assign yo_d = frame_start ? y_offset : yo_q;
    assign dy_d = $signed({3'b000, y_cnt}) - $signed({3'b000, yo_d});

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (line_start) state_d = CALC;
            CALC:    state_d = STEP;
            STEP:    state_d = SPAN;
            SPAN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign n_b = dy_q - H_N;
    assign n_c = dy_q - HD_N;

    cube_row_dda #(.W(W), .H(H), .WQ(WQ), .WR(WR), .QW(QW), .RW(RW), .NW(NW)) u_dda_a (
        .clk(clk), .rst_n(reset), .upd_i(state_q == CALC), .n_i(dy_q), .q_o(qa), .valid_o(va));
    cube_row_dda #(.W(W), .H(H), .WQ(WQ), .WR(WR), .QW(QW), .RW(RW), .NW(NW)) u_dda_b (
        .clk(clk), .rst_n(reset), .upd_i(state_q == CALC), .n_i(n_b), .q_o(qb), .valid_o(vb));
    cube_row_dda #(.W(W), .H(H), .WQ(WQ), .WR(WR), .QW(QW), .RW(RW), .NW(NW)) u_dda_c (
        .clk(clk), .rst_n(reset), .upd_i(state_q == CALC), .n_i(n_c), .q_o(qc), .valid_o(vc));

    // Span bounds are signed so bounds left of column 0 never wrap onto the far right.
    always_comb begin
        xo_s     = $signed({2'b00, lxo_q});
        qa_s     = $signed({{(SW-QW){1'b0}}, qa});
        qb_s     = $signed({{(SW-QW){1'b0}}, qb});
        qc_s     = $signed({{(SW-QW){1'b0}}, qc});
        in_a     = !dy_q[NW-1] && (dy_q <= H_N);
        in_b     = (dy_q > H_N) && (dy_q < H2_N);
        half     = in_a ? qa_s : (W_S - qb_s);
        top_ok_d = (in_a && va) || (in_b && vb);
        hi       = (qb_s < WM1_S) ? qb_s : WM1_S;
        lo       = '0;
        if (vc) lo = (qc_s < W_S) ? (qc_s + ONE_S) : W_S;
        lr_ok_d  = (dy_q >= H_N) && (dy_q < H2D_N) && vb && (lo <= hi);
    end

    always_comb begin
        xs    = $signed({2'b00, x_cnt});
        hit_t = top_ok_q && (xs >= top_lo_q) && (xs <= top_hi_q);
        hit_l = lr_ok_q && (xs >= lft_lo_q) && (xs <= lft_hi_q);
        hit_r = lr_ok_q && (xs >= rgt_lo_q) && (xs <= rgt_hi_q);
        gate  = enable && seen_q && (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            xo_q     <= '0;
            yo_q     <= '0;
            seen_q   <= 1'b0;
            lxo_q    <= '0;
            dy_q     <= '0;
            top_ok_q <= 1'b0;
            lr_ok_q  <= 1'b0;
            top_lo_q <= '0;
            top_hi_q <= '0;
            lft_lo_q <= '0;
            lft_hi_q <= '0;
            rgt_lo_q <= '0;
            rgt_hi_q <= '0;
            top_q    <= 1'b0;
            left_q   <= 1'b0;
            right_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            if (frame_start) seen_q <= 1'b1;
            if (state_q == IDLE && line_start) begin
                lxo_q <= xo_d;
                dy_q  <= dy_d;
            end
            if (state_q == STEP) begin
                top_ok_q <= top_ok_d;
                lr_ok_q  <= lr_ok_d;
                top_lo_q <= xo_s - half;
                top_hi_q <= xo_s + half;
                lft_lo_q <= xo_s - W_S + lo;
                lft_hi_q <= xo_s - W_S + hi;
                rgt_lo_q <= xo_s + W_S - hi;
                rgt_hi_q <= xo_s + W_S - lo;
            end
            top_q   <= gate && hit_t;
            left_q  <= gate && hit_l && !hit_t;
            right_q <= gate && hit_r && !hit_t;
        end
    end

    assign top_face   = top_q;
    assign left_face  = left_q;
    assign right_face = right_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_cube_raster_gen.sv
// Bench for cube_raster_gen: fixed vectors for known rows plus random pixel probes
// checked against an arithmetic model of the face rules.
module tb_cube_raster_gen;

    localparam int XW = 11;
    localparam int YW = 10;
    localparam int W  = 90;
    localparam int H  = 50;
    localparam int D  = 120;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_start, line_start, enable;
    logic [XW-1:0] x_cnt, x_offset;
    logic [YW-1:0] y_cnt, y_offset;
    logic          top_face, left_face, right_face, busy;

    int checks   = 0;
    int failures = 0;
    logic [2:0] exp_q[$];

    typedef struct {
        int         fid;
        int         y;
        int         x;
        logic [2:0] exp_v;
        logic       en;
    } vec_t;
    vec_t vecs[$];

    cube_raster_gen #(.XW(XW), .YW(YW), .W(W), .H(H), .D(D)) dut (
        .clk(clk), .reset(rst_n), .frame_start(frame_start), .line_start(line_start),
        .x_cnt(x_cnt), .y_cnt(y_cnt), .x_offset(x_offset), .y_offset(y_offset),
        .enable(enable), .top_face(top_face), .left_face(left_face),
        .right_face(right_face), .busy(busy));

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // {top,left,right} straight from the face rules using plain integer arithmetic.
    function automatic logic [2:0] ref_face(int x, int y, int xo, int yo, bit en);
        int dy, ax, hi, lo;
        if (!en) return 3'b000;
        dy = y - yo;
        ax = (x > xo) ? x - xo : xo - x;
        if (dy >= 0 && dy <= H && ax <= dy * W / H) return 3'b100;
        if (dy > H && dy < 2 * H && ax <= W - (dy - H) * W / H) return 3'b100;
        if (dy >= H && dy < 2 * H + D) begin
            hi = (dy - H) * W / H;
            if (hi > W - 1) hi = W - 1;
            if (dy - H - D < 0) lo = 0;
            else begin
                lo = (dy - H - D) * W / H + 1;
                if (lo > W) lo = W;
            end
            if (lo <= hi) begin
                if (x >= xo - W + lo && x <= xo - W + hi) return 3'b010;
                if (x >= xo + W - hi && x <= xo + W - lo) return 3'b001;
            end
        end
        return 3'b000;
    endfunction

    task automatic check_val(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic probe(input int x, input logic [2:0] exp_v, input string name);
        logic [2:0] req;
        exp_q.push_back(exp_v);
        x_cnt = x[XW-1:0];
        @(negedge clk);
        req = exp_q.pop_front();
        checks++;
        if ({top_face, left_face, right_face} !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name,
                     {top_face, left_face, right_face}, req);
        end
    endtask

    task automatic do_line(input int y, input int xo, input bit fs_now,
                           input bit extra_ls, input bit extra_fs);
        int n;
        bit leak;
        x_cnt       = xo[XW-1:0];
        y_cnt       = y[YW-1:0];
        line_start  = 1'b1;
        frame_start = fs_now;
        @(negedge clk);
        line_start  = 1'b0;
        frame_start = 1'b0;
        n    = 0;
        leak = 1'b0;
        while (busy && n < 8) begin
            if (top_face || left_face || right_face) leak = 1'b1;
            if (n == 1) begin
                line_start  = extra_ls;
                frame_start = extra_fs;
            end
            @(negedge clk);
            line_start  = 1'b0;
            frame_start = 1'b0;
            n++;
        end
        check_val($sformatf("busy_cycles y%0d", y), n, 3);
        check_val($sformatf("busy_gate y%0d", y), int'(leak), 0);
    endtask

    task automatic run_lines(input int fid, input int y0, input int y1,
                             input int xo, input int yo, input bit fs_first);
        int rx, lo_x;
        bit en;
        for (int y = y0; y <= y1; y++) begin
            if (fid == 1 && y == 200) x_offset = 11'd600;
            do_line(y, xo, fs_first && (y == y0), 1'b0, 1'b0);
            foreach (vecs[i]) begin
                if (vecs[i].fid == fid && vecs[i].y == y) begin
                    enable = vecs[i].en;
                    probe(vecs[i].x, vecs[i].exp_v,
                          $sformatf("vec f%0d y%0d x%0d", fid, y, vecs[i].x));
                end
            end
            lo_x = (xo - W - 4 < 0) ? 0 : xo - W - 4;
            for (int k = 0; k < 3; k++) begin
                rx     = $urandom_range(xo + W + 4, lo_x);
                en     = ($urandom_range(7, 0) != 0);
                enable = en;
                probe(rx, ref_face(rx, y, xo, yo, en), $sformatf("rand y%0d x%0d", y, rx));
            end
            enable = 1'b1;
        end
    endtask

    initial begin
        vecs.push_back('{1, 100, 399, 3'b000, 1'b1});
        vecs.push_back('{1, 100, 400, 3'b100, 1'b1});
        vecs.push_back('{1, 100, 401, 3'b000, 1'b1});
        vecs.push_back('{1, 110, 381, 3'b000, 1'b1});
        vecs.push_back('{1, 110, 382, 3'b100, 1'b1});
        vecs.push_back('{1, 110, 418, 3'b100, 1'b1});
        vecs.push_back('{1, 110, 419, 3'b000, 1'b1});
        vecs.push_back('{1, 150, 309, 3'b000, 1'b1});
        vecs.push_back('{1, 150, 310, 3'b100, 1'b1});
        vecs.push_back('{1, 150, 490, 3'b100, 1'b1});
        vecs.push_back('{1, 150, 491, 3'b000, 1'b1});
        vecs.push_back('{1, 160, 309, 3'b000, 1'b1});
        vecs.push_back('{1, 160, 310, 3'b010, 1'b1});
        vecs.push_back('{1, 160, 327, 3'b010, 1'b1});
        vecs.push_back('{1, 160, 328, 3'b100, 1'b1});
        vecs.push_back('{1, 160, 472, 3'b100, 1'b1});
        vecs.push_back('{1, 160, 473, 3'b001, 1'b1});
        vecs.push_back('{1, 160, 490, 3'b001, 1'b1});
        vecs.push_back('{1, 160, 491, 3'b000, 1'b1});
        vecs.push_back('{1, 200, 399, 3'b010, 1'b1});
        vecs.push_back('{1, 200, 400, 3'b000, 1'b1});
        vecs.push_back('{1, 200, 401, 3'b001, 1'b1});
        vecs.push_back('{1, 200, 600, 3'b000, 1'b1});
        vecs.push_back('{1, 280, 328, 3'b000, 1'b1});
        vecs.push_back('{1, 280, 329, 3'b010, 1'b1});
        vecs.push_back('{1, 280, 399, 3'b010, 1'b1});
        vecs.push_back('{1, 280, 400, 3'b000, 1'b1});
        vecs.push_back('{1, 280, 401, 3'b001, 1'b1});
        vecs.push_back('{1, 280, 471, 3'b001, 1'b1});
        vecs.push_back('{1, 280, 472, 3'b000, 1'b1});
        vecs.push_back('{1, 320, 310, 3'b000, 1'b1});
        vecs.push_back('{1, 320, 400, 3'b000, 1'b1});
        vecs.push_back('{2, 100, 599, 3'b000, 1'b1});
        vecs.push_back('{2, 100, 600, 3'b100, 1'b1});
        vecs.push_back('{2, 100, 400, 3'b000, 1'b1});
        vecs.push_back('{3, 160, 0,    3'b100, 1'b1});
        vecs.push_back('{3, 160, 112,  3'b100, 1'b1});
        vecs.push_back('{3, 160, 113,  3'b001, 1'b1});
        vecs.push_back('{3, 160, 130,  3'b001, 1'b1});
        vecs.push_back('{3, 160, 131,  3'b000, 1'b1});
        vecs.push_back('{3, 160, 2047, 3'b000, 1'b1});
        vecs.push_back('{3, 160, 50,   3'b000, 1'b0});

        rst_n       = 1'b0;
        frame_start = 1'b0;
        line_start  = 1'b0;
        enable      = 1'b1;
        x_cnt       = '0;
        y_cnt       = '0;
        x_offset    = '0;
        y_offset    = '0;
        repeat (3) @(negedge clk);
        check_val("reset_outputs", int'({top_face, left_face, right_face, busy}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        probe(0, 3'b000, "post_reset x0");

        // Frame with top vertex at (400,100); x_offset moves to 600 mid-frame.
        x_offset    = 11'd400;
        y_offset    = 10'd100;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        run_lines(1, 95, 325, 400, 100, 1'b0);

        // New offsets latched on the same cycle as the first line_start.
        run_lines(2, 100, 169, 600, 100, 1'b1);

        // line_start and frame_start arriving mid-update: ignored / latched only.
        x_offset = 11'd40;
        y_offset = 10'd100;
        do_line(170, 600, 1'b0, 1'b1, 1'b1);
        probe(600, ref_face(600, 170, 600, 100, 1'b1), "old_frame y170 x600");
        probe(560, ref_face(560, 170, 600, 100, 1'b1), "old_frame y170 x560");
        check_val("no_extra_line", int'(busy), 0);

        run_lines(3, 100, 165, 40, 100, 1'b0);

        // Asynchronous reset while a face output is high.
        enable = 1'b1;
        probe(40, ref_face(40, 165, 40, 100, 1'b1), "pre_reset top");
        #2;
        rst_n = 1'b0;
        #1;
        check_val("reset_async", int'({top_face, left_face, right_face, busy}), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        probe(40, 3'b000, "after_reset x40");
        do_line(0, 0, 1'b0, 1'b0, 1'b0);
        probe(0, 3'b000, "no_frame_yet x0");
        probe(1, 3'b000, "no_frame_yet x1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
